// File: rtl/shift_rotate_unit_if.sv
// Command/data bus of shift_rotate_unit: load/start requests in, register state and handshake out.
interface shift_rotate_unit_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AMT_W = $clog2(WIDTH);

    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] Q;
    logic             carry_out;
    logic             busy;
    logic             done;

    modport master (
        output load, data_in, start, op, amount,
        input  Q, carry_out, busy, done
    );

    modport slave (
        input  load, data_in, start, op, amount,
        output Q, carry_out, busy, done
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-mode shift/rotate register with parallel load and a start/busy/done shift-by-N command.
// Define SHIFT_FAST_EN to replace the one-bit-per-cycle sequencer with a single-cycle barrel shifter.
module shift_rotate_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    shift_rotate_unit_if.slave   bus
);
    localparam int unsigned AMT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ROR = 3'd0;
    localparam logic [2:0] OP_ROL = 3'd1;
    localparam logic [2:0] OP_LSR = 3'd2;
    localparam logic [2:0] OP_LSL = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

`ifdef SHIFT_FAST_EN
    logic [2*WIDTH-1:0] ror_w, rol_w;
    logic [AMT_W-1:0]   rt_idx, lt_idx;
    logic [WIDTH-1:0]   sh_q;
    logic               sh_c;

    // Barrel result; the carry is the last bit that a sequential walk would have pushed out.
    always_comb begin
        rt_idx = bus.amount - AMT_W'(1);
        lt_idx = AMT_W'(32'(WIDTH) - 32'(bus.amount));
        ror_w  = {q_q, q_q} >> bus.amount;
        rol_w  = {q_q, q_q} << bus.amount;
        sh_q   = q_q;
        sh_c   = carry_q;
        case (bus.op)
            OP_ROR: begin sh_q = ror_w[WIDTH-1:0];       sh_c = q_q[rt_idx]; end
            OP_ROL: begin sh_q = rol_w[2*WIDTH-1:WIDTH]; sh_c = q_q[lt_idx]; end
            OP_LSR: begin sh_q = q_q >> bus.amount;      sh_c = q_q[rt_idx]; end
            OP_LSL: begin sh_q = q_q << bus.amount;      sh_c = q_q[lt_idx]; end
            OP_ASR: begin sh_q = WIDTH'($signed(q_q) >>> bus.amount); sh_c = q_q[rt_idx]; end
            default: ;
        endcase
        if (bus.amount == '0) sh_c = carry_q;
    end

    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        if (bus.load) begin
            q_d     = bus.data_in;
            carry_d = 1'b0;
        end else if (bus.start) begin
            q_d     = sh_q;
            carry_d = sh_c;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = 1'b0;
`else
    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    // One single-bit step; returns {carry, q}. Reserved ops hold both.
    function automatic logic [WIDTH:0] step_one(input logic [2:0] op,
                                               input logic [WIDTH-1:0] q,
                                               input logic c);
        case (op)
            OP_ROR:  step_one = {q[0],       q[0],       q[WIDTH-1:1]};
            OP_ROL:  step_one = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
            OP_LSR:  step_one = {q[0],       1'b0,       q[WIDTH-1:1]};
            OP_LSL:  step_one = {q[WIDTH-1], q[WIDTH-2:0], 1'b0};
            OP_ASR:  step_one = {q[0],       q[WIDTH-1], q[WIDTH-1:1]};
            default: step_one = {c, q};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        q_d     = q_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    q_d     = bus.data_in;
                    carry_d = 1'b0;
                end else if (bus.start) begin
                    op_d    = bus.op;
                    cnt_d   = bus.amount;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    {carry_d, q_d} = step_one(op_q, q_q, carry_q);
                    cnt_d          = cnt_q - AMT_W'(1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            q_q     <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_q     <= q_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
`endif

    assign bus.Q         = q_q;
    assign bus.carry_out = carry_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit: commands push expected {Q, carry} and a monitor checks on done.
module tb_shift_rotate_unit;
    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             c;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];

    shift_rotate_unit_if #(.WIDTH(WIDTH)) bus ();

    shift_rotate_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_q", 32'(bus.Q), 32'(e.q));
                check("result_carry", 32'(bus.carry_out), 32'(e.c));
            end
        end
    end

    task automatic do_load(input logic [WIDTH-1:0] v);
        @(negedge clock);
        bus.load    = 1'b1;
        bus.data_in = v;
        @(negedge clock);
        bus.load    = 1'b0;
        check("load_q", 32'(bus.Q), 32'(v));
        check("load_carry", 32'(bus.carry_out), 32'd0);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [2:0] amt,
                          input logic [WIDTH-1:0] eq, input logic ec, input bit disturb);
        int lat;
        int busy_cyc;
        bit seen;
        int exp_lat;
        sb_q.push_back('{q: eq, c: ec});
        @(negedge clock);
        bus.op     = op;
        bus.amount = amt;
        bus.start  = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            if (disturb && lat == 2) begin
                bus.load    = 1'b1;
                bus.start   = 1'b1;
                bus.data_in = '0;
            end else begin
                bus.load  = 1'b0;
                bus.start = 1'b0;
            end
            lat++;
            @(negedge clock);
        end
        bus.load  = 1'b0;
        bus.start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
`ifdef SHIFT_FAST_EN
        exp_lat = 0;
`else
        exp_lat = int'(amt) + 1;
`endif
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cyc), 32'(exp_lat));
        check("busy_low_at_done", 32'(bus.busy), 32'd0);
        @(negedge clock);
        check("done_single_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load    = 1'b0;
        bus.data_in = '0;
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.amount  = '0;
        @(negedge clock);
        @(negedge clock);
        check("rst_q", 32'(bus.Q), 32'd0);
        check("rst_carry", 32'(bus.carry_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;

        do_load(8'b1001_0110);
        do_cmd(3'd0, 3'd3, 8'b1101_0010, 1'b1, 1'b0);   // ROR 3
        do_load(8'b1000_0100);
        do_cmd(3'd4, 3'd2, 8'b1110_0001, 1'b0, 1'b0);   // ASR 2
        do_load(8'b1000_0001);
        do_cmd(3'd3, 3'd1, 8'b0000_0010, 1'b1, 1'b0);   // LSL 1
        do_load(8'b1000_0001);
        do_cmd(3'd1, 3'd1, 8'b0000_0011, 1'b1, 1'b0);   // ROL 1
        do_load(8'b1011_0100);
        do_cmd(3'd2, 3'd3, 8'b0001_0110, 1'b1, 1'b0);   // LSR 3
        do_load(8'h4B);
        do_cmd(3'd0, 3'd1, 8'hA5, 1'b1, 1'b0);          // ROR 1 -> A5, carry 1
        do_cmd(3'd1, 3'd0, 8'hA5, 1'b1, 1'b0);          // ROL 0 holds everything
        do_load(8'h3C);
        do_cmd(3'd5, 3'd2, 8'h3C, 1'b0, 1'b0);          // reserved op
        do_load(8'hFF);
        do_cmd(3'd2, 3'd7, 8'h01, 1'b1, 1'b1);          // LSR 7 with mid-command load+start

`ifndef SHIFT_FAST_EN
        // Reset two steps into ROR 5 of 0x5A (carry is 1 by then).
        do_load(8'h5A);
        @(negedge clock);
        bus.op     = 3'd0;
        bus.amount = 3'd5;
        bus.start  = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_reset_carry", 32'(bus.carry_out), 32'd1);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_q", 32'(bus.Q), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_carry", 32'(bus.carry_out), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check("post_rst_done", 32'(bus.done), 32'd0);
`endif

        // load and start together: load wins, no command runs.
        @(negedge clock);
        bus.load    = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = 8'h3C;
        bus.op      = 3'd0;
        bus.amount  = 3'd1;
        @(negedge clock);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        check("load_wins_q", 32'(bus.Q), 32'h3C);
        check("load_wins_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clock);
        check("load_wins_q_stable", 32'(bus.Q), 32'h3C);

        repeat (2) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
